// File: rtl/ball_motion_ctrl_pkg.sv
// Shared definitions for the ball motion controller: state and direction
// encodings, event vector layout and the motion-code helper.
package ball_motion_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_PLAY  = 2'd2,
      ST_PAUSE = 2'd3
   } ball_state_e;

   localparam int H_STOP_DEF = 11;
   localparam int V_STOP_DEF = 10;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;

   // Bit positions within the latched event vector
   localparam int EV_TOP    = 0;
   localparam int EV_BOTTOM = 1;
   localparam int EV_LEFT   = 2;
   localparam int EV_RIGHT  = 3;
   localparam int EV_PADDLE = 4;
   localparam int EV_W      = 5;

   function automatic logic [3:0] move_code(input logic [3:0] stop,
                                            input logic [3:0] speed,
                                            input logic       dir);
      return dir ? (stop + speed) : (stop - speed);
   endfunction

endpackage

// File: rtl/ball_event_latch.sv
// Sticky set-on-pulse event flags. ev_now folds in the current-cycle pulse so
// a pulse coincident with frame_start is seen by that boundary.
module ball_event_latch #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         ball_reset,
   input  logic         frame_start,
   input  logic         flush,
   input  logic [W-1:0] ev_in,
   output logic [W-1:0] ev_now
);

   logic [W-1:0] pend_q, pend_d;

   always_comb begin
      ev_now = pend_q | ev_in;
      pend_d = (frame_start || flush) ? '0 : ev_now;
   end

   always_ff @(posedge clk or posedge ball_reset) begin
      if (ball_reset) pend_q <= '0;
      else            pend_q <= pend_d;
   end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Serve/play/pause sequencer producing frame-aligned horizontal and vertical
// motion codes for the slipping-counter ball datapath.
module ball_motion_ctrl
   import ball_motion_ctrl_pkg::*;
#(
   parameter int H_STOP           = H_STOP_DEF,
   parameter int V_STOP           = V_STOP_DEF,
   parameter int INIT_SPEED       = 1,
   parameter int MAX_SPEED        = 4,
   parameter int HITS_PER_SPEEDUP = 4,
   parameter int PAUSE_FRAMES     = 60
) (
   input  logic       clk,
   input  logic       ball_reset,
   input  logic       frame_start,
   input  logic       serve_req,
   input  logic       serve_dir,
   input  logic       hit_top,
   input  logic       hit_bottom,
   input  logic       hit_left,
   input  logic       hit_right,
   input  logic       paddle_hit,
   output logic [3:0] h_move,
   output logic [3:0] v_move,
   output logic       ball_active,
   output logic       point_left,
   output logic       point_right,
   output logic [1:0] state
);

   localparam logic [3:0]  H_STOP4    = 4'(H_STOP);
   localparam logic [3:0]  V_STOP4    = 4'(V_STOP);
   localparam logic [3:0]  INIT_SPD   = 4'(INIT_SPEED);
   localparam logic [3:0]  MAX_SPD    = 4'(MAX_SPEED);
   localparam logic [7:0]  HIT_WRAP   = 8'(HITS_PER_SPEEDUP - 1);
   localparam logic [15:0] PAUSE_LOAD = 16'(PAUSE_FRAMES - 1);

   ball_state_e state_q, state_d;
   logic [3:0]  speed_q, speed_d;
   logic        hdir_q, hdir_d;
   logic        vdir_q, vdir_d;
   logic [7:0]  hit_cnt_q, hit_cnt_d;
   logic [15:0] pause_cnt_q, pause_cnt_d;
   logic [3:0]  h_move_q, h_move_d;
   logic [3:0]  v_move_q, v_move_d;
   logic        ball_active_q, ball_active_d;
   logic        point_left_q, point_left_d;
   logic        point_right_q, point_right_d;
   logic [EV_W-1:0] ev_in, ev_now;

   always_comb begin
      ev_in            = '0;
      ev_in[EV_TOP]    = hit_top;
      ev_in[EV_BOTTOM] = hit_bottom;
      ev_in[EV_LEFT]   = hit_left;
      ev_in[EV_RIGHT]  = hit_right;
      ev_in[EV_PADDLE] = paddle_hit;
   end

   // Events only matter during PLAY; anything seen elsewhere is discarded.
   ball_event_latch #(.W(EV_W)) u_ev_latch (
      .clk         (clk),
      .ball_reset  (ball_reset),
      .frame_start (frame_start),
      .flush       (state_q != ST_PLAY),
      .ev_in       (ev_in),
      .ev_now      (ev_now)
   );

   always_comb begin
      state_d       = state_q;
      speed_d       = speed_q;
      hdir_d        = hdir_q;
      vdir_d        = vdir_q;
      hit_cnt_d     = hit_cnt_q;
      pause_cnt_d   = pause_cnt_q;
      point_left_d  = 1'b0;
      point_right_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (serve_req) begin
               hdir_d    = serve_dir;
               vdir_d    = DIR_DOWN;
               speed_d   = INIT_SPD;
               hit_cnt_d = '0;
               state_d   = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (frame_start) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (frame_start) begin
               if (ev_now[EV_LEFT]) begin
                  point_right_d = 1'b1;
                  pause_cnt_d   = PAUSE_LOAD;
                  state_d       = ST_PAUSE;
               end else if (ev_now[EV_RIGHT]) begin
                  point_left_d = 1'b1;
                  pause_cnt_d  = PAUSE_LOAD;
                  state_d      = ST_PAUSE;
               end else begin
                  if (ev_now[EV_PADDLE]) begin
                     hdir_d = ~hdir_q;
                     if (hit_cnt_q == HIT_WRAP) begin
                        hit_cnt_d = '0;
                        if (speed_q < MAX_SPD) speed_d = speed_q + 4'd1;
                     end else begin
                        hit_cnt_d = hit_cnt_q + 8'd1;
                     end
                  end
                  // Walls set direction outright; both at once cancel out.
                  if (ev_now[EV_TOP] && !ev_now[EV_BOTTOM])      vdir_d = DIR_DOWN;
                  else if (ev_now[EV_BOTTOM] && !ev_now[EV_TOP]) vdir_d = DIR_UP;
               end
            end
         end
         ST_PAUSE: begin
            if (frame_start) begin
               if (pause_cnt_q == '0) state_d = ST_IDLE;
               else                   pause_cnt_d = pause_cnt_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ball_active_d = (state_d == ST_PLAY);
      h_move_d      = ball_active_d ? move_code(H_STOP4, speed_d, hdir_d) : H_STOP4;
      v_move_d      = ball_active_d ? move_code(V_STOP4, speed_d, vdir_d) : V_STOP4;
   end

   always_ff @(posedge clk or posedge ball_reset) begin
      if (ball_reset) begin
         state_q       <= ST_IDLE;
         speed_q       <= '0;
         hdir_q        <= DIR_RIGHT;
         vdir_q        <= DIR_DOWN;
         hit_cnt_q     <= '0;
         pause_cnt_q   <= '0;
         h_move_q      <= H_STOP4;
         v_move_q      <= V_STOP4;
         ball_active_q <= 1'b0;
         point_left_q  <= 1'b0;
         point_right_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         speed_q       <= speed_d;
         hdir_q        <= hdir_d;
         vdir_q        <= vdir_d;
         hit_cnt_q     <= hit_cnt_d;
         pause_cnt_q   <= pause_cnt_d;
         h_move_q      <= h_move_d;
         v_move_q      <= v_move_d;
         ball_active_q <= ball_active_d;
         point_left_q  <= point_left_d;
         point_right_q <= point_right_d;
      end
   end

   assign h_move      = h_move_q;
   assign v_move      = v_move_q;
   assign ball_active = ball_active_q;
   assign point_left  = point_left_q;
   assign point_right = point_right_q;
   assign state       = state_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed vector table, hand sequences for pause,
// saturation and async reset, then random stimulus against a game-rule model.
module tb_ball_motion_ctrl;

   localparam int HS = 11, VS = 10, INIT = 1, MAXS = 4, HPS = 4, PF = 60;

   logic clk = 1'b0;
   logic ball_reset, frame_start, serve_req, serve_dir;
   logic hit_top, hit_bottom, hit_left, hit_right, paddle_hit;
   logic [3:0] h_move, v_move;
   logic ball_active, point_left, point_right;
   logic [1:0] state;

   always #5 clk = ~clk;

   ball_motion_ctrl dut (
      .clk(clk), .ball_reset(ball_reset), .frame_start(frame_start),
      .serve_req(serve_req), .serve_dir(serve_dir),
      .hit_top(hit_top), .hit_bottom(hit_bottom), .hit_left(hit_left),
      .hit_right(hit_right), .paddle_hit(paddle_hit),
      .h_move(h_move), .v_move(v_move), .ball_active(ball_active),
      .point_left(point_left), .point_right(point_right), .state(state)
   );

   int total = 0, bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: game phase names and plain integer game quantities.
   // ev bits: 0 top, 1 bottom, 2 left goal, 3 right goal, 4 paddle.
   int m_phase, m_speed, m_hdir, m_vdir, m_hits, m_frames_left;
   bit [4:0] m_pending;
   bit m_pl, m_pr;

   task automatic model_reset();
      m_phase = 0; m_speed = 0; m_hdir = 1; m_vdir = 1; m_hits = 0;
      m_frames_left = 0; m_pending = '0; m_pl = 0; m_pr = 0;
   endtask

   task automatic model_step(input bit sr, input bit sd, input bit fs, input bit [4:0] ev);
      bit [4:0] seen;
      bit was_play;
      seen = m_pending | ev;
      was_play = (m_phase == 2);
      m_pl = 0; m_pr = 0;
      if (m_phase == 0) begin
         if (sr) begin
            m_hdir = sd; m_vdir = 1; m_speed = INIT; m_hits = 0; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (fs) m_phase = 2;
      end else if (m_phase == 2) begin
         if (fs) begin
            if (seen[2]) begin m_pr = 1; m_phase = 3; m_frames_left = PF; end
            else if (seen[3]) begin m_pl = 1; m_phase = 3; m_frames_left = PF; end
            else begin
               if (seen[4]) begin
                  m_hdir = 1 - m_hdir;
                  m_hits = (m_hits + 1) % HPS;
                  if (m_hits == 0) m_speed = (m_speed + 1 > MAXS) ? MAXS : m_speed + 1;
               end
               if (seen[0] && !seen[1]) m_vdir = 1;
               if (seen[1] && !seen[0]) m_vdir = 0;
            end
         end
      end else begin
         // frames_left counts the frame_starts still needed to leave PAUSE
         if (fs) begin
            m_frames_left--;
            if (m_frames_left == 0) m_phase = 0;
         end
      end
      m_pending = (was_play && !fs) ? seen : 5'b0;
   endtask

   function automatic int exp_h();
      return (m_phase == 2) ? (m_hdir ? HS + m_speed : HS - m_speed) : HS;
   endfunction
   function automatic int exp_v();
      return (m_phase == 2) ? (m_vdir ? VS + m_speed : VS - m_speed) : VS;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, " state"}, state, m_phase);
      chk({tag, " h_move"}, h_move, exp_h());
      chk({tag, " v_move"}, v_move, exp_v());
      chk({tag, " active"}, ball_active, (m_phase == 2) ? 1 : 0);
      chk({tag, " point_left"}, point_left, m_pl);
      chk({tag, " point_right"}, point_right, m_pr);
   endtask

   // Apply one cycle of inputs; returns at posedge+1 with pulses cleared.
   task automatic cycle(input bit sr, input bit sd, input bit fs, input bit [4:0] ev);
      serve_req = sr; serve_dir = sd; frame_start = fs;
      hit_top = ev[0]; hit_bottom = ev[1]; hit_left = ev[2];
      hit_right = ev[3]; paddle_hit = ev[4];
      model_step(sr, sd, fs, ev);
      @(posedge clk);
      #1;
      serve_req = 0; frame_start = 0;
      hit_top = 0; hit_bottom = 0; hit_left = 0; hit_right = 0; paddle_hit = 0;
   endtask

   task automatic do_reset();
      ball_reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1 ball_reset = 1'b0;
   endtask

   typedef struct {
      bit sr, sd, fs;
      bit [4:0] ev;
      int st, h, v, act, pl, pr;
   } vec_t;

   localparam bit [4:0] E_TOP = 5'b00001, E_BOT = 5'b00010, E_LEFT = 5'b00100,
                        E_RIGHT = 5'b01000, E_PAD = 5'b10000, E_NONE = 5'b00000;

   vec_t tbl[14];

   function automatic vec_t mk(bit sr, bit sd, bit fs, bit [4:0] ev,
                               int st, int h, int v, int act, int pl, int pr);
      vec_t r;
      r.sr = sr; r.sd = sd; r.fs = fs; r.ev = ev;
      r.st = st; r.h = h; r.v = v; r.act = act; r.pl = pl; r.pr = pr;
      return r;
   endfunction

   initial begin
      tbl[0]  = mk(1, 1, 0, E_NONE,        1, 11, 10, 0, 0, 0);
      tbl[1]  = mk(0, 0, 1, E_NONE,        2, 12, 11, 1, 0, 0);
      tbl[2]  = mk(0, 0, 0, E_PAD,         2, 12, 11, 1, 0, 0);
      tbl[3]  = mk(0, 0, 1, E_NONE,        2, 10, 11, 1, 0, 0);
      tbl[4]  = mk(0, 0, 1, E_PAD,         2, 12, 11, 1, 0, 0);
      tbl[5]  = mk(0, 0, 1, E_PAD,         2, 10, 11, 1, 0, 0);
      tbl[6]  = mk(0, 0, 1, E_PAD,         2, 13, 12, 1, 0, 0);
      tbl[7]  = mk(0, 0, 1, E_TOP | E_BOT, 2, 13, 12, 1, 0, 0);
      tbl[8]  = mk(0, 0, 0, E_BOT,         2, 13, 12, 1, 0, 0);
      tbl[9]  = mk(0, 0, 0, E_BOT,         2, 13, 12, 1, 0, 0);
      tbl[10] = mk(0, 0, 1, E_BOT,         2, 13,  8, 1, 0, 0);
      tbl[11] = mk(1, 0, 0, E_NONE,        2, 13,  8, 1, 0, 0);
      tbl[12] = mk(0, 0, 1, E_RIGHT|E_PAD, 3, 11, 10, 0, 1, 0);
      tbl[13] = mk(0, 0, 0, E_NONE,        3, 11, 10, 0, 0, 0);

      serve_req = 0; serve_dir = 0; frame_start = 0;
      hit_top = 0; hit_bottom = 0; hit_left = 0; hit_right = 0; paddle_hit = 0;
      ball_reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset state", state, 0);
      chk("reset h_move", h_move, HS);
      chk("reset v_move", v_move, VS);
      chk("reset active", ball_active, 0);
      chk("reset points", {point_left, point_right}, 0);
      ball_reset = 1'b0;

      foreach (tbl[i]) begin
         cycle(tbl[i].sr, tbl[i].sd, tbl[i].fs, tbl[i].ev);
         chk($sformatf("vec%0d state", i), state, tbl[i].st);
         chk($sformatf("vec%0d h_move", i), h_move, tbl[i].h);
         chk($sformatf("vec%0d v_move", i), v_move, tbl[i].v);
         chk($sformatf("vec%0d active", i), ball_active, tbl[i].act);
         chk($sformatf("vec%0d point_left", i), point_left, tbl[i].pl);
         chk($sformatf("vec%0d point_right", i), point_right, tbl[i].pr);
      end

      // Pause holds for 59 more frame_starts, leaves on the 60th.
      for (int f = 1; f < PF; f++) begin
         cycle(0, 0, 1, E_NONE);
         chk($sformatf("pause hold f%0d", f), state, 3);
      end
      cycle(0, 0, 1, E_NONE);
      chk("pause exit state", state, 0);

      // Serve left, then run speed to saturation.
      cycle(1, 0, 0, E_NONE);
      chk("serve2 state", state, 1);
      cycle(0, 0, 1, E_NONE);
      chk("serve2 h_move", h_move, 10);
      for (int k = 0; k < 16; k++) begin
         cycle(0, 0, 1, E_PAD);
         chk($sformatf("sat hit%0d h range", k), (h_move == 7 || h_move == 15) ? 1 : 0,
             (k >= 11) ? 1 : 0);
      end
      chk("sat h_move", h_move, 7);
      chk("sat v_move", v_move, 14);

      // Both goals on the frame_start cycle itself: left goal wins.
      cycle(0, 0, 1, E_LEFT | E_RIGHT);
      chk("goal pr", point_right, 1);
      chk("goal pl", point_left, 0);
      chk("goal state", state, 3);
      cycle(0, 0, 0, E_NONE);
      chk("goal pr pulse width", point_right, 0);

      // Async reset in PLAY with an event pending; the pending flag must not survive.
      do_reset();
      cycle(1, 1, 0, E_NONE);
      cycle(0, 0, 1, E_NONE);
      chk("play2 h_move", h_move, 12);
      cycle(0, 0, 0, E_PAD);
      #2 ball_reset = 1'b1;
      #1;
      chk("async rst state", state, 0);
      chk("async rst h_move", h_move, HS);
      chk("async rst v_move", v_move, VS);
      chk("async rst active", ball_active, 0);
      model_reset();
      @(posedge clk);
      #1 ball_reset = 1'b0;
      cycle(1, 1, 0, E_NONE);
      cycle(0, 0, 1, E_NONE);
      chk("post rst h_move", h_move, 12);
      chk("post rst v_move", v_move, 11);

      // Random play against the model.
      for (int n = 0; n < 6000; n++) begin
         bit [4:0] ev;
         ev[0] = ($urandom % 12) == 0;
         ev[1] = ($urandom % 12) == 0;
         ev[2] = ($urandom % 90) == 0;
         ev[3] = ($urandom % 90) == 0;
         ev[4] = ($urandom % 8) == 0;
         if (($urandom % 2500) == 0) begin
            do_reset();
         end else begin
            cycle(($urandom % 10) == 0, $urandom % 2, ($urandom % 5) == 0, ev);
            check_model($sformatf("rnd%0d", n));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
